divider: RTL and testbench
==========================

# divider

Sequential signed 32-bit integer divider that pairs with `multiplier` in the arithmetic unit. It computes X / Y with truncation toward zero and returns quotient and remainder. It uses a radix-2 non-restoring algorithm on operand magnitudes over a 33-bit partial-remainder datapath, the same width as the unit's 33-bit adder path. A start/busy/done handshake lets the top-level control sequence it the same way it sequences the multiplier.

## Interface
Parameters:
- `WIDTH`, 32: operand width. Only 32 is verified.

Ports:
- `clk`, in, 1: single clock; every register updates on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: request a division. Sampled only in IDLE.
- `X`, in, 32: dividend, two's complement. Captured on the accepting edge.
- `Y`, in, 32: divisor, two's complement. Captured on the accepting edge.
- `quotient`, out, 32: signed quotient. Held until the next completion.
- `remainder`, out, 32: signed remainder. Held until the next completion.
- `dbz`, out, 1: divide-by-zero flag for the last completed operation.
- `busy`, out, 1: high from the accepting edge until done falls.
- `done`, out, 1: one-cycle completion pulse.

## Operation
- State machine uses one-hot states IDLE, ITER, CORR, DONE.
- IDLE, start=1, Y≠0:
  - load A=0 (33 bits), Q=|X| (32 bits), M={1'b0,|Y|} (33 bits);
  - store sX=X[31] and sQ=X[31]^Y[31];
  - clear the iteration counter (5 bits);
  - go to ITER.
- IDLE, start=1, Y=0: go straight to DONE with quotient=32'hFFFF_FFFF, remainder=X, dbz=1. No iterations are run.
- ITER, one step per cycle:
  - {A,Q} shifts left 1;
  - if the old A[32]=0 then A=A−M, else A=A+M;
  - Q[0] = ~new A[32];
  - the counter increments;
  - after the 32nd step (counter wraps 31→0) go to CORR.
- CORR:
  - if A[32]=1 then A=A+M (remainder restore);
  - quotient = sQ ? −Q : Q;
  - remainder = sX ? −A[31:0] : A[31:0];
  - dbz=0;
  - go to DONE.
- DONE: done=1 for this cycle only, then return to IDLE.
- Arithmetic rules:
  - magnitudes are taken modulo 2^32, so |−2^31| = 32'h8000_0000 unsigned;
  - −2^31 / −1 gives quotient 32'h8000_0000 and remainder 0, with no flag;
  - the remainder sign follows the dividend, or it is zero.
- start while busy is ignored. The operands captured at acceptance stay in use.
- rst at any time, including mid-ITER, takes the next state to IDLE and clears all outputs.

## Timing
- Reset value of every output (quotient, remainder, dbz, busy, done) is 0.
- Normal path, with the accepting edge called E0:
  - ITER runs on edges E1..E32;
  - CORR is entered after E32;
  - results and done=1 register on edge E33;
  - done falls and busy falls on edge E34.
  - Latency from accepting edge to done is 33 cycles.
- Divide-by-zero path: results and done=1 register on E1; busy falls on E2.
- start held high through DONE is accepted again on the IDLE edge that follows. Back-to-back throughput is one operation every 35 cycles.
- Outputs are registered. No combinational path exists from inputs to outputs.

## Structure
- Shared package `arith_pkg` holds:
  - one-hot state localparams DIV_IDLE, DIV_ITER, DIV_CORR, DIV_DONE;
  - `DIV_STEPS` = 32;
  - `DIV_DBZ_Q` = 32'hFFFF_FFFF.
- One sub-module `div_addsub`: 33-bit add/subtract selected by a `sub` input. It is built as operand XOR `sub` plus carry-in `sub`, following the unit's existing adder style. It is shared by the ITER and CORR steps.
- Sign negation of the results uses a second `div_addsub` instance or an inline two's complement.

## Test plan
- X=72, Y=9, start pulsed: quotient=8, remainder=0, dbz=0, done exactly 33 cycles after acceptance, busy high throughout.
- X=−7, Y=2: quotient=32'hFFFF_FFFD (−3), remainder=32'hFFFF_FFFF (−1). With X=7, Y=−2: quotient=−3, remainder=1.
- X=5, Y=0: quotient=32'hFFFF_FFFF, remainder=5, dbz=1, done 1 cycle after acceptance. A following 10/3 returns 3, 1 with dbz cleared.
- X=32'h8000_0000, Y=32'hFFFF_FFFF: quotient=32'h8000_0000, remainder=0, dbz=0.
- Start 100/7, then pulse start again with 9/3 at cycle 10: result is still 14, 2, and the second request is not queued.
- Start 1000/10, assert rst at cycle 15: all outputs 0 and state IDLE. A new start then yields 100, 0 after 33 cycles.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared constants for the arithmetic unit: divider state encoding and step count.
// No logic; no latency.
// No flow control.
package arith_pkg;

    typedef enum logic [3:0] {
        DIV_IDLE = 4'b0001,
        DIV_ITER = 4'b0010,
        DIV_CORR = 4'b0100,
        DIV_DONE = 4'b1000
    } div_state_t;

    localparam int          DIV_STEPS = 32;
    localparam logic [31:0] DIV_DBZ_Q = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_addsub.sv
// Add/subtract for the divider's partial-remainder path; sub=1 gives a-b.
// Purely combinational, zero latency.
// No flow control.
module div_addsub #(
    parameter int W = 33
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] y
);

    assign y = a + (b ^ {W{sub}}) + W'(sub);

endmodule

// File: rtl/divider.sv
// Sequential signed divider, radix-2 non-restoring on operand magnitudes, truncating toward zero.
// Latency: done 33 cycles after the accepting edge (1 cycle for a zero divisor); one op every 35 cycles.
// Backpressure: start is sampled only while idle; requests made while busy are dropped.
module divider
    import arith_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dbz,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(DIV_STEPS);

    div_state_t       state, state_nxt;
    logic [WIDTH:0]   acc;
    logic [WIDTH:0]   m;
    logic [WIDTH-1:0] q;
    logic [CW-1:0]    cnt;
    logic             sx;
    logic             sq;
    logic             zdiv;

    logic             y_zero;
    logic             last_step;
    logic [WIDTH-1:0] abs_x;
    logic [WIDTH-1:0] abs_y;
    logic [WIDTH:0]   as_a;
    logic             as_sub;
    logic [WIDTH:0]   as_y;
    logic [WIDTH:0]   fixed;

    assign y_zero    = (Y == '0);
    assign last_step = (cnt == CW'(DIV_STEPS - 1));
    assign abs_x     = X[WIDTH-1] ? -X : X;
    assign abs_y     = Y[WIDTH-1] ? -Y : Y;

    // One adder serves both the iteration step and the final remainder restore.
    assign as_a   = (state == DIV_ITER) ? {acc[WIDTH-1:0], q[WIDTH-1]} : acc;
    assign as_sub = (state == DIV_ITER) ? ~acc[WIDTH] : 1'b0;
    assign fixed  = acc[WIDTH] ? as_y : acc;

    div_addsub #(.W(WIDTH + 1)) u_addsub (
        .a   (as_a),
        .b   (m),
        .sub (as_sub),
        .y   (as_y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= DIV_IDLE;
        else     state <= state_nxt;
    end

    // A zero divisor skips ITER and takes the CORR slot, so its results
    // register one edge after acceptance.
    always_comb begin
        state_nxt = state;
        case (state)
            DIV_IDLE: if (start) state_nxt = y_zero ? DIV_CORR : DIV_ITER;
            DIV_ITER: if (last_step) state_nxt = DIV_CORR;
            DIV_CORR: state_nxt = DIV_DONE;
            DIV_DONE: state_nxt = DIV_IDLE;
            default:  state_nxt = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            m         <= '0;
            q         <= '0;
            cnt       <= '0;
            sx        <= 1'b0;
            sq        <= 1'b0;
            zdiv      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            dbz       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (start) begin
                        // For a zero divisor |X| parks in acc so CORR re-signs it back to X.
                        acc  <= y_zero ? {1'b0, abs_x} : '0;
                        q    <= abs_x;
                        m    <= {1'b0, abs_y};
                        sx   <= X[WIDTH-1];
                        sq   <= X[WIDTH-1] ^ Y[WIDTH-1];
                        cnt  <= '0;
                        zdiv <= y_zero;
                        busy <= 1'b1;
                    end
                end
                DIV_ITER: begin
                    acc <= as_y;
                    q   <= {q[WIDTH-2:0], ~as_y[WIDTH]};
                    cnt <= cnt + 1'b1;
                end
                DIV_CORR: begin
                    acc       <= fixed;
                    quotient  <= zdiv ? WIDTH'(DIV_DBZ_Q) : (sq ? -q : q);
                    remainder <= sx ? -fixed[WIDTH-1:0] : fixed[WIDTH-1:0];
                    dbz       <= zdiv;
                    done      <= 1'b1;
                end
                DIV_DONE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                end
                default: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for divider: stimulus queues expected results, a negedge monitor checks them.
module tb_divider;
    import arith_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] X = '0;
    logic [31:0] Y = '0;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        dbz;
    logic        busy;
    logic        done;

    divider #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .X         (X),
        .Y         (Y),
        .quotient  (quotient),
        .remainder (remainder),
        .dbz       (dbz),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        int          acc;
        int          lat;
        string       name;
    } res_t;

    // kind: 0 outputs, 1 outputs+idle state, 2 timeout, 3 scoreboard empty, 4 busy high
    typedef struct {
        int          kind;
        string       name;
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        logic        busy;
        logic        done;
    } snap_t;

    res_t  sb[$];
    snap_t sn[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        res_t  e;
        snap_t s;
        if (done) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 q=%h r=%h want no completion", quotient, remainder);
            end else begin
                e = sb.pop_front();
                chk({e.name, "_q"}, quotient, e.q);
                chk({e.name, "_r"}, remainder, e.r);
                chk({e.name, "_dbz"}, {31'b0, dbz}, {31'b0, e.dbz});
                chk({e.name, "_lat"}, 32'(cyc - e.acc), 32'(e.lat));
                chk({e.name, "_busy"}, {31'b0, busy}, 32'd1);
            end
        end
        while (sn.size() > 0) begin
            s = sn.pop_front();
            case (s.kind)
                0, 1: begin
                    chk({s.name, "_q"}, quotient, s.q);
                    chk({s.name, "_r"}, remainder, s.r);
                    chk({s.name, "_dbz"}, {31'b0, dbz}, {31'b0, s.dbz});
                    chk({s.name, "_busy"}, {31'b0, busy}, {31'b0, s.busy});
                    chk({s.name, "_done"}, {31'b0, done}, {31'b0, s.done});
                    if (s.kind == 1)
                        chk({s.name, "_state"}, 32'(dut.state), 32'(DIV_IDLE));
                end
                2: begin
                    total++;
                    bad++;
                    $display("FAIL %s_timeout: got busy=%b pending=%0d want idle", s.name, busy, sb.size());
                end
                3: chk(s.name, 32'(sb.size()), 32'd0);
                default: chk({s.name, "_busy"}, {31'b0, busy}, 32'd1);
            endcase
        end
    end

    task automatic snap(input int k, input string nm, input logic [31:0] q, input logic [31:0] r,
                        input logic d, input logic b, input logic dn);
        snap_t s;
        s.kind = k; s.name = nm; s.q = q; s.r = r; s.dbz = d; s.busy = b; s.done = dn;
        sn.push_back(s);
    endtask

    task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic [31:0] eq,
                         input logic [31:0] er, input logic ed, input int lat,
                         input string nm, input bit push);
        res_t e;
        @(posedge clk); #1;
        start = 1'b1; X = x; Y = y;
        @(posedge clk); #1;
        start = 1'b0; X = 32'hDEAD_BEEF; Y = 32'h0;
        if (push) begin
            e.q = eq; e.r = er; e.dbz = ed; e.acc = cyc; e.lat = lat; e.name = nm;
            sb.push_back(e);
        end
        snap(4, {nm, "_accept"}, 0, 0, 0, 1, 0);
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while ((busy || sb.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) snap(2, nm, 0, 0, 0, 0, 0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk); #1;
        snap(1, "reset", 0, 0, 0, 0, 0);
        rst = 1'b0;

        issue(32'd72, 32'd9, 32'd8, 32'd0, 1'b0, 33, "div72_9", 1'b1);
        wait_idle("div72_9");
        issue(32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33, "neg7_2", 1'b1);
        wait_idle("neg7_2");
        issue(32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 33, "7_neg2", 1'b1);
        wait_idle("7_neg2");
        issue(32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, 1'b0, 33, "neg100_neg7", 1'b1);
        wait_idle("neg100_neg7");
        issue(32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1, "dbz5", 1'b1);
        wait_idle("dbz5");
        issue(32'd10, 32'd3, 32'd3, 32'd1, 1'b0, 33, "after_dbz", 1'b1);
        wait_idle("after_dbz");
        issue(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 33, "min_neg1", 1'b1);
        wait_idle("min_neg1");

        // second request while busy must be dropped
        issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, "busy_restart", 1'b1);
        repeat (9) @(posedge clk); #1;
        start = 1'b1; X = 32'd9; Y = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle("busy_restart");
        repeat (40) @(negedge clk);
        snap(0, "held", 32'd14, 32'd2, 1'b0, 1'b0, 1'b0);

        // reset mid-iteration
        issue(32'd1000, 32'd10, 0, 0, 1'b0, 0, "rst_mid", 1'b0);
        repeat (13) @(posedge clk); #1;
        rst = 1'b1;
        #1;
        snap(1, "rst_mid", 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        issue(32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 33, "post_rst", 1'b1);
        wait_idle("post_rst");

        snap(3, "sb_empty", 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
